// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display blocks.
//   state_e   : controller states
//   SEG_*     : active-low 7-segment glyphs {dp,g,f,e,d,c,b,a}, dp off
//   BCD_W     : width of one BCD digit
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h98;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low 7-segment pattern.
//   bcd     : 4-bit BCD digit; codes 10..15 render blank
//   dp_en   : 1 lights the decimal point
//   segment : active-low {dp,g,f,e,d,c,b,a}
import stopwatch_pkg::*;

module seg7_encode (
  input  logic [BCD_W-1:0] bcd,
  input  logic             dp_en,
  output logic [7:0]       segment
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    // dp is independent of the digit glyph
    segment = {~dp_en, glyph[6:0]};
  end

endmodule

// File: rtl/stopwatch_scan.sv
// N-digit BCD stopwatch with start/stop/lap/clear control and a
// multiplexed active-low 7-segment display driver. Single clock; the
// count tick and the digit scan are clock enables from prescalers.
//   clk, reset_n           : clock, async active-low reset
//   start/stop/lap/clear   : one-cycle control pulses (clear>stop>start>lap)
//   count                  : live BCD count, digit 0 in [3:0]
//   segment                : active-low {dp,g,f,e,d,c,b,a} of scanned digit
//   anodes                 : active-low one-hot digit select
//   running/lap_active     : RUN or LAP / LAP
//   overflow               : sticky, set when all-9s receives a tick
import stopwatch_pkg::*;

module stopwatch_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 50000,
  parameter int WRAP       = 1,
  parameter int DP_POS     = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        lap,
  input  logic                        clear,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic [7:0]                  segment,
  output logic [NUM_DIGITS-1:0]       anodes,
  output logic                        running,
  output logic                        lap_active,
  output logic                        overflow
);

  localparam int TW     = $clog2(TICK_DIV);
  localparam int SW     = $clog2(SCAN_DIV);
  localparam int IW     = $clog2(NUM_DIGITS);
  localparam bit DP_ON  = (DP_POS < NUM_DIGITS);
  localparam int DP_IDX = DP_ON ? DP_POS : 0;

  state_e state_q, state_d;
  logic   cap_lap;

  logic [NUM_DIGITS-1:0][BCD_W-1:0] count_q, count_inc, count_d, lap_q, disp;
  logic [NUM_DIGITS:0]              carry;

  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] scan_idx;
  logic          ovf_q;
  logic          run_en, tick;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Only the highest-priority asserted pulse is considered; if it is not
  // meaningful in the current state, nothing happens.
  always_comb begin
    state_d = state_q;
    cap_lap = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN || state_q == LAP) state_d = PAUSE;
    end else if (start) begin
      if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
    end else if (lap) begin
      if (state_q == RUN) begin
        state_d = LAP;
        cap_lap = 1'b1;
      end else if (state_q == LAP) begin
        state_d = RUN;
      end
    end
  end

  assign run_en = (state_q == RUN) || (state_q == LAP);
  assign tick   = run_en && (tick_cnt == TW'(TICK_DIV - 1));

  // ---------------- BCD chain ----------------
  assign carry[0] = tick;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_bcd
      logic at9;
      assign at9          = (count_q[i] == BCD_W'(9));
      assign carry[i+1]   = carry[i] && at9;
      assign count_inc[i] = !carry[i] ? count_q[i] :
                            at9       ? '0         :
                                        count_q[i] + BCD_W'(1);
    end
  endgenerate

  // carry out of the top digit means the count was all 9s on a tick
  assign count_d = (carry[NUM_DIGITS] && WRAP == 0) ? count_q : count_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      lap_q    <= '0;
      tick_cnt <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      count_q  <= '0;
      lap_q    <= '0;
      tick_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (carry[NUM_DIGITS]) ovf_q <= 1'b1;
      // capture pre-increment value when a tick lands on the lap edge
      if (cap_lap) lap_q <= count_q;
      // prescaler is held outside RUN/LAP so a resume keeps the phase
      if (run_en) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

  // ---------------- display scan ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_an
      assign anodes[i] = (scan_idx != IW'(i));
    end
  endgenerate

  assign disp = (state_q == LAP) ? lap_q : count_q;

  logic [BCD_W-1:0] disp_digit;
  logic             dp_en;

  assign disp_digit = disp[scan_idx];
  assign dp_en      = DP_ON && (scan_idx == IW'(DP_IDX));

  seg7_encode u_seg (
    .bcd     (disp_digit),
    .dp_en   (dp_en),
    .segment (segment)
  );

  assign count      = count_q;
  assign running    = run_en;
  assign lap_active = (state_q == LAP);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_scan.sv
module tb_stopwatch_scan;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SD = 2;
  localparam int DP = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;

  logic [15:0] count;
  logic [7:0]  segment;
  logic [3:0]  anodes;
  logic        running, lap_active, overflow;

  logic [7:0]  cw, cs, segw, segs;
  logic [1:0]  anw, ans;
  logic        runw, runs, lapw, laps, ovfw, ovfs;

  always #5 clk = ~clk;

  stopwatch_scan #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD), .WRAP(1), .DP_POS(DP)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
    .count(count), .segment(segment), .anodes(anodes), .running(running),
    .lap_active(lap_active), .overflow(overflow));

  stopwatch_scan #(.NUM_DIGITS(2), .TICK_DIV(2), .SCAN_DIV(2), .WRAP(1), .DP_POS(5)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
    .count(cw), .segment(segw), .anodes(anw), .running(runw),
    .lap_active(lapw), .overflow(ovfw));

  stopwatch_scan #(.NUM_DIGITS(2), .TICK_DIV(2), .SCAN_DIV(2), .WRAP(0), .DP_POS(5)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
    .count(cs), .segment(segs), .anodes(ans), .running(runs),
    .lap_active(laps), .overflow(ovfs));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------- reference model: elapsed ticks as an integer ----------
  // states: 0 idle, 1 run, 2 pause, 3 lap
  int m_state, m_val, m_lap, m_pre, m_ovf, m_scnt, m_sidx;
  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

  task automatic model_reset();
    m_state = 0; m_val = 0; m_lap = 0; m_pre = 0; m_ovf = 0; m_scnt = 0; m_sidx = 0;
  endtask

  task automatic model_step();
    int old;
    bit run, tk;
    old = m_val;
    run = (m_state == 1) || (m_state == 3);
    tk  = run && (m_pre == TD - 1);
    if (clear) begin
      m_state = 0; m_val = 0; m_lap = 0; m_pre = 0; m_ovf = 0;
    end else begin
      if (tk) begin
        if (m_val == 9999) begin m_ovf = 1; m_val = 0; end
        else m_val = m_val + 1;
      end
      if (run) m_pre = (m_pre + 1) % TD;
      if (stop) begin
        if (run) m_state = 2;
      end else if (start) begin
        if (m_state == 0 || m_state == 2) m_state = 1;
      end else if (lap) begin
        if (m_state == 1) begin m_state = 3; m_lap = old; end
        else if (m_state == 3) m_state = 1;
      end
    end
    if (m_scnt == SD - 1) begin m_scnt = 0; m_sidx = (m_sidx + 1) % N; end
    else m_scnt = m_scnt + 1;
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check_all();
    int disp, t;
    logic [7:0] es;
    disp = (m_state == 3) ? m_lap : m_val;
    t = disp;
    for (int i = 0; i < m_sidx; i++) t = t / 10;
    es = glyph[t % 10];
    if (m_sidx == DP) es[7] = 1'b0;
    chk("count",      32'(count),      32'(to_bcd(m_val)));
    chk("running",    32'(running),    32'(m_state == 1 || m_state == 3));
    chk("lap_active", 32'(lap_active), 32'(m_state == 3));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("anodes",     32'(anodes),     32'(4'(~(32'd1 << m_sidx))));
    chk("segment",    32'(segment),    32'(es));
  endtask

  // one clock: drive pulses {clear,stop,start,lap} at negedge, hold through posedge
  task automatic cyc(input logic [3:0] p);
    {clear, stop, start, lap} = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
    {clear, stop, start, lap} = 4'b0000;
  endtask

  typedef struct {
    logic [3:0]  p;
    int          n;
    logic [15:0] cnt;
    logic        run;
    logic        lapa;
    logic        ovf;
  } vec_t;

  vec_t tbl [13];
  logic [3:0] scan_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    // {clear,stop,start,lap}, idle cycles after the pulse, expected state
    tbl[0]  = '{4'b0010, 40, 16'h0010, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100,  5, 16'h0010, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0010,  3, 16'h0011, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b0001,  1, 16'h0011, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4'b0010,  1, 16'h0012, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{4'b0001,  0, 16'h0012, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{4'b0110,  0, 16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0110,  3, 16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b0001,  2, 16'h0012, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1010,  0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{4'b0100,  1, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0010,  7, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{4'b1010,  2, 16'h0000, 1'b0, 1'b0, 1'b0};

    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // reset values
    chk("rst_count",   32'(count),   32'h0);
    chk("rst_segment", 32'(segment), 32'hC0);
    chk("rst_anodes",  32'(anodes),  32'hE);
    chk("rst_run",     32'(running), 32'h0);
    chk("rst_seg_w",   32'(segw),    32'hC0);
    chk("rst_an_w",    32'(anw),     32'h2);
    check_all();

    // scan sequence with dp on digit 3 only
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc(4'b0000);
      chk("scan_anodes", 32'(anodes),     32'(scan_exp[(k/2)%4]));
      chk("scan_dp",     32'(segment[7]), 32'(((k/2)%4) == 3 ? 1'b0 : 1'b1));
    end

    // table-driven control vectors from a cleared state
    cyc(4'b1000);
    for (int v = 0; v < 13; v++) begin
      cyc(tbl[v].p);
      repeat (tbl[v].n) cyc(4'b0000);
      chk($sformatf("vec%0d_count", v), 32'(count),      32'(tbl[v].cnt));
      chk($sformatf("vec%0d_run", v),   32'(running),    32'(tbl[v].run));
      chk($sformatf("vec%0d_lap", v),   32'(lap_active), 32'(tbl[v].lapa));
      chk($sformatf("vec%0d_ovf", v),   32'(overflow),   32'(tbl[v].ovf));
      check_all();
    end

    // lap freeze: digit 0 keeps showing 5 while the count moves on
    cyc(4'b1000);
    cyc(4'b0010);
    repeat (20) cyc(4'b0000);
    chk("lap_pre_count", 32'(count), 32'h0005);
    cyc(4'b0001);
    chk("lap_enter", 32'(lap_active), 32'h1);
    for (int k = 0; k < 20; k++) begin
      cyc(4'b0000);
      if (m_sidx == 0) chk("lap_frozen_d0", 32'(segment), 32'h92);
      check_all();
    end
    chk("lap_live_count", 32'(count), 32'h0010);
    cyc(4'b0001);
    chk("lap_exit", 32'(lap_active), 32'h0);
    chk("lap_exit_run", 32'(running), 32'h1);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0000);
      check_all();
    end

    // overflow on the 2-digit instances: 99 ticks, then the 100th
    cyc(4'b1000);
    cyc(4'b0010);
    repeat (198) cyc(4'b0000);
    chk("ovf_w_99",   32'(cw),   32'h99);
    chk("ovf_s_99",   32'(cs),   32'h99);
    chk("ovf_w_pre",  32'(ovfw), 32'h0);
    chk("ovf_s_pre",  32'(ovfs), 32'h0);
    repeat (2) cyc(4'b0000);
    chk("ovf_w_wrap", 32'(cw),   32'h00);
    chk("ovf_w_flag", 32'(ovfw), 32'h1);
    chk("ovf_w_run",  32'(runw), 32'h1);
    chk("ovf_s_hold", 32'(cs),   32'h99);
    chk("ovf_s_flag", 32'(ovfs), 32'h1);
    chk("ovf_s_run",  32'(runs), 32'h1);
    repeat (10) cyc(4'b0000);
    chk("ovf_w_cont",   32'(cw),   32'h05);
    chk("ovf_w_sticky", 32'(ovfw), 32'h1);
    chk("ovf_s_cont",   32'(cs),   32'h99);
    check_all();
    cyc(4'b1000);
    chk("ovf_clr_w",     32'(ovfw), 32'h0);
    chk("ovf_clr_s",     32'(ovfs), 32'h0);
    chk("ovf_clr_run",   32'(runs), 32'h0);
    chk("ovf_clr_count", 32'(cs),   32'h00);

    // randomized control against the model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] p;
      r = $urandom_range(0, 199);
      if (r == 0)      p = 4'b1000;
      else if (r < 4)  p = 4'b0100;
      else if (r < 9)  p = 4'b0010;
      else if (r < 13) p = 4'b0001;
      else if (r < 15) p = 4'($urandom_range(0, 15));
      else             p = 4'b0000;
      cyc(p);
      check_all();
    end

    // asynchronous reset in the middle of RUN
    cyc(4'b1000);
    cyc(4'b0010);
    repeat (9) cyc(4'b0000);
    chk("arst_pre_count", 32'(count), 32'h0002);
    @(posedge clk);
    model_step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count",   32'(count),      32'h0);
    chk("arst_run",     32'(running),    32'h0);
    chk("arst_lap",     32'(lap_active), 32'h0);
    chk("arst_ovf",     32'(overflow),   32'h0);
    chk("arst_anodes",  32'(anodes),     32'hE);
    chk("arst_segment", 32'(segment),    32'hC0);
    chk("arst_count_w", 32'(cw),         32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
    cyc(4'b0010);
    repeat (5) cyc(4'b0000);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
